// File: rtl/free_list_int.sv
// free_list_int: circular free list of integer physical register indices for rename.
//
// Supplies up to ALLOC_WIDTH free PRF indices per cycle. Allocation is all-or-nothing.
// Retiring instructions return their stale destination registers at the tail.
// A pipeline clear rewinds the speculative head to the committed head.
//
// Ports:
//   clock, reset        clock and synchronous active-high reset
//   clear_i             pipeline flush; head <= commit_head (after this cycle's commits)
//   alloc_req_i         per-slot request for a new prd
//   alloc_grant_o       every requesting slot receives an index this cycle
//   alloc_index_o       prd per requesting slot (0 for non-requesting slots)
//   commit_valid_i      retiring instruction on commit port k
//   commit_has_rd_i     retiring instruction on port k allocated a prd
//   commit_old_prd_i    stale prd returned by port k
//   free_count_o        allocatable entries, from registered state only
//
// Optional: define FREE_LIST_INT_CHECK_EN to compile in simulation-only consistency checks
// and a per-cycle pointer trace.
module free_list_int #(
    parameter int unsigned PRF_SIZE    = 64,
    parameter int unsigned ARCH_REGS   = 32,
    parameter int unsigned INDEX_SIZE  = 6,
    parameter int unsigned ALLOC_WIDTH = 4,
    parameter int unsigned FREE_WIDTH  = 4,
    localparam int unsigned DEPTH      = PRF_SIZE - ARCH_REGS,
    localparam int unsigned PTR_SIZE   = $clog2(DEPTH) + 1
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   clear_i,
    input  logic [ALLOC_WIDTH-1:0]                 alloc_req_i,
    output logic                                   alloc_grant_o,
    output logic [ALLOC_WIDTH-1:0][INDEX_SIZE-1:0] alloc_index_o,
    input  logic [FREE_WIDTH-1:0]                  commit_valid_i,
    input  logic [FREE_WIDTH-1:0]                  commit_has_rd_i,
    input  logic [FREE_WIDTH-1:0][INDEX_SIZE-1:0]  commit_old_prd_i,
    output logic [PTR_SIZE-1:0]                    free_count_o
);

    localparam int unsigned IDX_W = PTR_SIZE - 1;

    typedef logic [PTR_SIZE-1:0] ptr_t;

    logic [INDEX_SIZE-1:0] entries_q [DEPTH];
    ptr_t head_q, head_d;
    ptr_t commit_head_q, commit_head_d;
    ptr_t tail_q, tail_d;
    ptr_t n_req;
    ptr_t free_cnt;
    logic grant;

    logic [FREE_WIDTH-1:0] wr_en;
    logic [IDX_W-1:0]      wr_idx [FREE_WIDTH];

    // Requesting slots read consecutive entries from head, packed in slot order.
    always_comb begin
        n_req = '0;
        for (int k = 0; k < ALLOC_WIDTH; k++) begin
            alloc_index_o[k] = '0;
            if (alloc_req_i[k]) begin
                alloc_index_o[k] = entries_q[IDX_W'(head_q + n_req)];
                n_req = n_req + ptr_t'(1);
            end
        end
    end

    assign free_cnt      = tail_q - head_q;
    assign grant         = !reset && !clear_i && (free_cnt >= n_req);
    assign alloc_grant_o = grant;
    assign free_count_o  = free_cnt;

    // Every retiring rd advances commit_head; only nonzero old prds are written back, so
    // p0 never enters the list.
    always_comb begin
        commit_head_d = commit_head_q;
        tail_d        = tail_q;
        for (int k = 0; k < FREE_WIDTH; k++) begin
            wr_en[k]  = 1'b0;
            wr_idx[k] = IDX_W'(tail_d);
            if (commit_valid_i[k] && commit_has_rd_i[k]) begin
                commit_head_d = commit_head_d + ptr_t'(1);
                if (commit_old_prd_i[k] != '0) begin
                    wr_en[k] = 1'b1;
                    tail_d   = tail_d + ptr_t'(1);
                end
            end
        end
    end

    always_comb begin
        if (clear_i) begin
            head_d = commit_head_d;
        end else if (grant) begin
            head_d = head_q + n_req;
        end else begin
            head_d = head_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= INDEX_SIZE'(ARCH_REGS + i);
            end
            head_q        <= '0;
            commit_head_q <= '0;
            tail_q        <= ptr_t'(DEPTH);  // wrap bit set: list full
        end else begin
            for (int k = 0; k < FREE_WIDTH; k++) begin
                if (wr_en[k]) begin
                    entries_q[wr_idx[k]] <= commit_old_prd_i[k];
                end
            end
            head_q        <= head_d;
            commit_head_q <= commit_head_d;
            tail_q        <= tail_d;
        end
    end

`ifdef FREE_LIST_INT_CHECK_EN
    logic print_en;
    ptr_t chk_fill;
    ptr_t chk_spec;

    assign print_en = 1'b0;
    assign chk_fill = tail_d - commit_head_d;
    assign chk_spec = head_d - commit_head_d;

    always @(posedge clock) begin
        if (!reset) begin
            if (chk_fill > ptr_t'(DEPTH)) begin
                $error("free_list_int: overflow or double free (tail - commit_head = %0d)",
                       chk_fill);
            end
            // A negative spec distance wraps to a large unsigned value.
            if (chk_spec > ptr_t'(DEPTH)) begin
                $error("free_list_int: commit_head passed head");
            end
            for (int k = 0; k < FREE_WIDTH; k++) begin
                if (wr_en[k]) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (ptr_t'(i) < free_cnt &&
                            entries_q[IDX_W'(head_q + ptr_t'(i))] == commit_old_prd_i[k]) begin
                            $error("free_list_int: p%0d freed while already free",
                                   commit_old_prd_i[k]);
                        end
                    end
                end
            end
            if (print_en) begin
                $display("free_list_int: head=%0d commit_head=%0d tail=%0d free_count=%0d",
                         head_q, commit_head_q, tail_q, free_cnt);
            end
        end
    end
`endif

endmodule
